// File: rtl/gpu_pkg.sv
// Shared types and opcode field layout for the host instruction queue.
package gpu_pkg;
  localparam int INSTR_W     = 32;
  localparam int OPC_LEN_MSB = 7;
  localparam int OPC_LEN_LSB = 6;

  typedef enum logic [1:0] {IDLE, ARGS, HOLD} asm_state_t;

  // Number of argument bytes that follow an opcode.
  function automatic logic [1:0] opc_nargs(input logic [7:0] opc);
    return opc[OPC_LEN_MSB:OPC_LEN_LSB];
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy count; head reads as zero when empty.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic              do_push, do_pop;

  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && valid;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= push_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/instruction_queue.sv
// Assembles byte-serial host writes into variable-length instructions and
// queues them for the command decoder.
module instruction_queue #(
  parameter int DATA_W      = 8,
  parameter int INSTR_W     = gpu_pkg::INSTR_W,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_we,
  input  logic                       i_en,
  input  logic [DATA_W-1:0]          i_data,
  output logic                       o_ack,
  input  logic                       i_flush,
  input  logic                       i_clr_ovf,
  output logic [INSTR_W-1:0]         o_instruction,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_overflow
);
  import gpu_pkg::*;

  logic strb, strb_s, strb_q, byte_ev;

  assign strb = !i_we && !i_en;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign strb_s = strb;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync;
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) sync <= '0;
        else begin
          sync[0] <= strb;
          for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
        end
      end
      assign strb_s = sync[SYNC_STAGES-1];
    end
  endgenerate

  // One event per strobe: the rising edge of the synchronised level.
  assign byte_ev = strb_s && !strb_q;

  asm_state_t         state, state_n;
  logic [INSTR_W-1:0] word, word_n, push_data;
  logic [1:0]         rem, rem_n, slot;
  logic               ack_n, ovf_set, push, pop, space, fifo_valid, fifo_full;

  assign pop   = fifo_valid && i_ready;
  assign space = !fifo_full || pop;

  always_comb begin
    state_n   = state;
    word_n    = word;
    rem_n     = rem;
    slot      = '0;
    ack_n     = 1'b0;
    ovf_set   = 1'b0;
    push      = 1'b0;
    push_data = word;
    if (i_flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (byte_ev) begin
          ack_n                = 1'b1;
          word_n               = '0;
          word_n[DATA_W-1:0]   = i_data;
          if (opc_nargs(i_data) == 2'd0) begin
            push_data = word_n;
            if (space) push = 1'b1;
            else       state_n = HOLD;
          end else begin
            rem_n   = opc_nargs(i_data);
            state_n = ARGS;
          end
        end
        ARGS: if (byte_ev) begin
          ack_n  = 1'b1;
          slot   = opc_nargs(word[7:0]) - rem + 2'd1;
          word_n[slot*DATA_W +: DATA_W] = i_data;
          rem_n  = rem - 2'd1;
          if (rem == 2'd1) begin
            push_data = word_n;
            if (space) begin
              push    = 1'b1;
              state_n = IDLE;
            end else begin
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          // The assembler is busy with a completed word; new bytes are lost.
          ovf_set = byte_ev;
          if (space) begin
            push    = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      word       <= '0;
      rem        <= '0;
      strb_q     <= 1'b0;
      o_ack      <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state  <= state_n;
      word   <= word_n;
      rem    <= rem_n;
      strb_q <= strb_s;
      o_ack  <= ack_n;
      if (ovf_set)        o_overflow <= 1'b1;
      else if (i_clr_ovf) o_overflow <= 1'b0;
    end
  end

  sync_fifo #(.DATA_W(INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (i_clk),
    .rst       (i_reset),
    .flush     (i_flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (o_instruction),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .count     (o_count)
  );

  assign o_valid = fifo_valid;
  assign o_full  = fifo_full;
endmodule
